// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID/EX hazard and forwarding controller.
// The optional condition-code register is enabled with HAZARD_FWD_CCR_EN.
package hazard_pkg;

    localparam int TRK_REG_W = 3;

    localparam logic [1:0] FWD_REG   = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;
    localparam logic [1:0] FWD_LOAD  = 2'd3;

    localparam logic [3:0] OP_NOP = 4'd0;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic [TRK_REG_W-1:0] dst;
        logic                 wr;
        logic                 load;
    } stage_t;

    // Z and N are touched only by arithmetic/logic opcodes.
    function automatic logic op_sets_zn(input logic [3:0] op);
        logic res;
        case (op)
            4'd0, 4'd4, 4'd13, 4'd14, 4'd15: res = 1'b0;
            default:                         res = 1'b1;
        endcase
        return res;
    endfunction

    function automatic logic op_sets_c(input logic [3:0] op);
        logic res;
        if ((op >= 4'd1) && (op <= 4'd12)) begin
            res = 1'b1;
        end else begin
            res = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_sel_unit.sv
// Operand forwarding select for one source operand, evaluated at decode time
// against the producers currently tracked in EX and MEM.
module fwd_sel_unit
    import hazard_pkg::*;
(
    input  logic                 i_use,
    input  logic [TRK_REG_W-1:0] i_reg,
    input  stage_t               i_ex,
    input  stage_t               i_mem,
    output logic [1:0]           o_sel
);

    // Youngest matching producer wins; a MEM load forwards raw memory data.
    always_comb begin
        o_sel = FWD_REG;
        if (!i_use) begin
            o_sel = FWD_REG;
        end else if (i_ex.valid && i_ex.wr && (i_ex.dst == i_reg)) begin
            o_sel = FWD_EXMEM;
        end else if (i_mem.valid && i_mem.wr && (i_mem.dst == i_reg)) begin
            if (i_mem.load) begin
                o_sel = FWD_LOAD;
            end else begin
                o_sel = FWD_MEMWB;
            end
        end else begin
            o_sel = FWD_REG;
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// ID/EX boundary controller: destination tracking, load-use stall, forwarding
// selects and EX opcode register. HAZARD_FWD_CCR_EN adds the condition codes.
module hazard_fwd_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W = 3,
    parameter int OP_W  = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src,
    input  logic [REG_W-1:0] id_dst,
    input  logic             id_use_src,
    input  logic             id_use_dst,
    input  logic             id_wr,
    input  logic             id_load,
    input  logic [OP_W-1:0]  id_op,
    input  logic             flush,
`ifdef HAZARD_FWD_CCR_EN
    input  logic [2:0]       alu_flags,
    output logic [2:0]       ccr,
`endif
    output logic             stall,
    output logic [OP_W-1:0]  ex_op,
    output logic [1:0]       fwd_src_sel,
    output logic [1:0]       fwd_dst_sel,
    output logic             ex_valid,
    output logic [CNT_W-1:0] stall_cnt
);

    state_t           r_state;
    stage_t           r_ex;
    stage_t           r_mem;
    logic [OP_W-1:0]  r_ex_op;
    logic [1:0]       r_src_sel;
    logic [1:0]       r_dst_sel;
    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_load_use;
    logic             w_stall;
    logic [1:0]       w_src_sel;
    logic [1:0]       w_dst_sel;
    stage_t           w_ex_next;
    logic [OP_W-1:0]  w_op_next;
    logic [1:0]       w_src_next;
    logic [1:0]       w_dst_next;

    fwd_sel_unit u_src_sel (
        .i_use (id_use_src & id_valid),
        .i_reg (id_src),
        .i_ex  (r_ex),
        .i_mem (r_mem),
        .o_sel (w_src_sel)
    );

    fwd_sel_unit u_dst_sel (
        .i_use (id_use_dst & id_valid),
        .i_reg (id_dst),
        .i_ex  (r_ex),
        .i_mem (r_mem),
        .o_sel (w_dst_sel)
    );

    // Load in EX whose result the decode instruction needs right away.
    always_comb begin
        w_load_use = id_valid & r_ex.valid & r_ex.wr & r_ex.load &
                     ((id_use_src & (id_src == r_ex.dst)) |
                      (id_use_dst & (id_dst == r_ex.dst)));
        if (r_state == RUN) begin
            w_stall = w_load_use & ~flush;
        end else begin
            w_stall = 1'b0;
        end
    end

    // Next EX contents: a bubble on flush or stall, else the decode slot.
    always_comb begin
        w_ex_next  = '0;
        w_op_next  = OP_W'(OP_NOP);
        w_src_next = FWD_REG;
        w_dst_next = FWD_REG;
        if (flush || w_stall) begin
            w_ex_next  = '0;
            w_op_next  = OP_W'(OP_NOP);
            w_src_next = FWD_REG;
            w_dst_next = FWD_REG;
        end else begin
            w_ex_next.valid = id_valid;
            w_ex_next.dst   = id_dst;
            w_ex_next.wr    = id_wr & id_valid;
            w_ex_next.load  = id_load & id_valid;
            w_op_next       = id_valid ? id_op : OP_W'(OP_NOP);
            w_src_next      = w_src_sel;
            w_dst_next      = w_dst_sel;
        end
    end

    // Pipeline tracking and EX capture; MEM always advances, even during a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex      <= '0;
            r_mem     <= '0;
            r_ex_op   <= OP_W'(OP_NOP);
            r_src_sel <= FWD_REG;
            r_dst_sel <= FWD_REG;
        end else begin
            r_mem     <= r_ex;
            r_ex      <= w_ex_next;
            r_ex_op   <= w_op_next;
            r_src_sel <= w_src_next;
            r_dst_sel <= w_dst_next;
        end
    end

    // Stall FSM: STALL lasts one cycle, and the counter saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RUN;
            r_stall_cnt <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                RUN: begin
                    if (w_stall) begin
                        r_state <= STALL;
                        if (r_stall_cnt != {CNT_W{1'b1}}) begin
                            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
                        end
                    end else begin
                        r_state <= RUN;
                    end
                end
                STALL: begin
                    r_state <= RUN;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

`ifdef HAZARD_FWD_CCR_EN
    logic [2:0] r_ccr;

    // Condition codes follow the instruction leaving EX; bit 2 is C, 1 is Z, 0 is N.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ccr <= 3'b000;
        end else if (r_ex.valid) begin
            if (op_sets_zn(r_ex_op)) begin
                r_ccr[1:0] <= alu_flags[1:0];
            end
            if (op_sets_c(r_ex_op)) begin
                r_ccr[2] <= alu_flags[2];
            end
        end
    end

    assign ccr = r_ccr;
`endif

    assign stall       = w_stall;
    assign ex_op       = r_ex_op;
    assign fwd_src_sel = r_src_sel;
    assign fwd_dst_sel = r_dst_sel;
    assign ex_valid    = r_ex.valid;
    assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Scoreboard bench for hazard_fwd_ctrl: directed pipeline scenarios, then random
// instruction streams, checked against an instruction-level reference model.
module tb_hazard_fwd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [2:0]  id_src;
    logic [2:0]  id_dst;
    logic        id_use_src;
    logic        id_use_dst;
    logic        id_wr;
    logic        id_load;
    logic [3:0]  id_op;
    logic        flush;
    logic [2:0]  alu_flags;
    logic [2:0]  ccr_s;
    logic        stall;
    logic [3:0]  ex_op;
    logic [1:0]  fwd_src_sel;
    logic [1:0]  fwd_dst_sel;
    logic        ex_valid;
    logic [15:0] stall_cnt;

    hazard_fwd_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_src      (id_src),
        .id_dst      (id_dst),
        .id_use_src  (id_use_src),
        .id_use_dst  (id_use_dst),
        .id_wr       (id_wr),
        .id_load     (id_load),
        .id_op       (id_op),
        .flush       (flush),
`ifdef HAZARD_FWD_CCR_EN
        .alu_flags   (alu_flags),
        .ccr         (ccr_s),
`endif
        .stall       (stall),
        .ex_op       (ex_op),
        .fwd_src_sel (fwd_src_sel),
        .fwd_dst_sel (fwd_dst_sel),
        .ex_valid    (ex_valid),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    // One in-flight instruction as the model sees it.
    typedef struct {
        bit v;
        int dst;
        bit wr;
        bit ld;
        int op;
        int ssel;
        int dsel;
    } ent_t;

    typedef struct {
        int stall;
        int op;
        int v;
        int ss;
        int ds;
        int cnt;
        int ccr;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    ent_t m_ex;
    ent_t m_mem;
    bit   m_stalled;
    int   m_cnt;
    int   m_ccr;
    bit   last_stall;

    function automatic ent_t empty_ent();
        ent_t e;
        e.v = 1'b0; e.dst = 0; e.wr = 1'b0; e.ld = 1'b0; e.op = 0; e.ssel = 0; e.dsel = 0;
        return e;
    endfunction

    function automatic int pick(bit use_r, int r, ent_t ex, ent_t mem);
        if (!use_r) return 0;
        if (ex.v && ex.wr && ex.dst == r) return 1;
        if (mem.v && mem.wr && mem.dst == r) return mem.ld ? 3 : 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_ex = empty_ent();
        m_mem = empty_ent();
        m_stalled = 1'b0;
        m_cnt = 0;
        m_ccr = 0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus; pushes what the DUT must show during this cycle.
    task automatic drive(input bit v, input int s, input int d, input bit us, input bit ud,
                         input bit wr, input bit ld, input int op, input bit fl,
                         input bit rs, input int flags);
        bit   hazard;
        bit   e_stall;
        exp_t e;
        ent_t n;
        @(posedge clk);
        #1;
        rst = rs; id_valid = v; id_src = 3'(s); id_dst = 3'(d);
        id_use_src = us; id_use_dst = ud; id_wr = wr; id_load = ld;
        id_op = 4'(op); flush = fl; alu_flags = 3'(flags);

        hazard = v && m_ex.v && m_ex.wr && m_ex.ld &&
                 ((us && s == m_ex.dst) || (ud && d == m_ex.dst));
        e_stall = !m_stalled && hazard && !fl;
        e.stall = e_stall; e.op = m_ex.op; e.v = m_ex.v; e.ss = m_ex.ssel;
        e.ds = m_ex.dsel; e.cnt = m_cnt; e.ccr = m_ccr;
        q.push_back(e);
        last_stall = e_stall;

        if (rs) begin
            model_reset();
        end else begin
            if (m_ex.v) begin
                if (!(m_ex.op == 0 || m_ex.op == 4 || m_ex.op >= 13))
                    m_ccr = (m_ccr & 4) | (flags & 3);
                if (m_ex.op >= 1 && m_ex.op <= 12)
                    m_ccr = (m_ccr & 3) | (flags & 4);
            end
            n = empty_ent();
            if (!(fl || e_stall)) begin
                n.v = v; n.dst = d; n.wr = wr && v; n.ld = ld && v; n.op = v ? op : 0;
                n.ssel = pick(us && v, s, m_ex, m_mem);
                n.dsel = pick(ud && v, d, m_ex, m_mem);
            end
            m_mem = m_ex;
            m_ex = n;
            if (e_stall && m_cnt != 16'hFFFF) m_cnt++;
            m_stalled = e_stall;
        end
    endtask

    // Issue an instruction, re-presenting it while decode is held.
    task automatic issue(input bit v, input int s, input int d, input bit us, input bit ud,
                         input bit wr, input bit ld, input int op, input int flags);
        int n = 0;
        do begin
            drive(v, s, d, us, ud, wr, ld, op, 1'b0, 1'b0, flags);
            n++;
        end while (last_stall && n < 3);
    endtask

    task automatic nops(input int k);
        for (int i = 0; i < k; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares every cycle the scoreboard has an expectation for.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("stall", 32'(stall), 32'(e.stall));
                chk("ex_op", 32'(ex_op), 32'(e.op));
                chk("ex_valid", 32'(ex_valid), 32'(e.v));
                chk("fwd_src_sel", 32'(fwd_src_sel), 32'(e.ss));
                chk("fwd_dst_sel", 32'(fwd_dst_sel), 32'(e.ds));
                chk("stall_cnt", 32'(stall_cnt), 32'(e.cnt));
`ifdef HAZARD_FWD_CCR_EN
                chk("ccr", 32'(ccr_s), 32'(e.ccr));
`endif
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit v, us, ud, wr, ld, fl, rs;
        int s, d, op, fg;
        rst = 1'b1; id_valid = 1'b0; id_src = 3'd0; id_dst = 3'd0; id_use_src = 1'b0;
        id_use_dst = 1'b0; id_wr = 1'b0; id_load = 1'b0; id_op = 4'd0; flush = 1'b0;
        alu_flags = 3'd0;
        model_reset();
        last_stall = 1'b0;
        repeat (3) @(posedge clk);

        // ADD r1 then SUB reading r1
        issue(1, 0, 1, 0, 0, 1, 0, 1, 0);
        issue(1, 1, 5, 1, 0, 1, 0, 2, 0);
        nops(2);
        // ADD r2, bubble, reader of r2 as dst
        issue(1, 0, 2, 0, 0, 1, 0, 1, 0);
        nops(1);
        issue(1, 0, 2, 0, 1, 0, 0, 3, 0);
        nops(2);
        // LDD r3 then immediate reader
        issue(1, 0, 3, 0, 0, 1, 1, 8, 0);
        issue(1, 3, 6, 1, 0, 1, 0, 1, 0);
        nops(2);
        // LDD r3, reader squashed by flush in the hazard cycle
        issue(1, 0, 3, 0, 0, 1, 1, 8, 0);
        drive(1, 3, 6, 1, 0, 1, 0, 1, 1, 0, 0);
        nops(2);
        // r4 produced in both EX and MEM
        issue(1, 0, 4, 0, 0, 1, 0, 1, 0);
        issue(1, 0, 4, 0, 0, 1, 0, 2, 0);
        issue(1, 4, 7, 1, 0, 1, 0, 3, 0);
        nops(2);
        // Reset asserted while a load-use stall is raised
        issue(1, 0, 5, 0, 0, 1, 1, 8, 0);
        drive(1, 5, 6, 1, 0, 1, 0, 1, 0, 1, 0);
        drive(1, 5, 6, 1, 0, 1, 0, 1, 0, 0, 0);
        nops(2);
        // Condition codes: op 5 updates, op 13 does not
        issue(1, 0, 1, 0, 0, 1, 0, 5, 0);
        issue(1, 0, 2, 0, 0, 1, 0, 13, 3'b010);
        issue(1, 0, 0, 0, 0, 0, 0, 0, 3'b101);
        nops(2);

        v = 0; s = 0; d = 0; us = 0; ud = 0; wr = 0; ld = 0; op = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!last_stall) begin
                v  = ($urandom_range(0, 9) < 8);
                s  = $urandom_range(0, 3);
                d  = $urandom_range(0, 3);
                us = $urandom_range(0, 1);
                ud = $urandom_range(0, 1);
                wr = ($urandom_range(0, 3) != 0);
                ld = ($urandom_range(0, 2) == 0);
                op = $urandom_range(0, 15);
            end
            fl = ($urandom_range(0, 9) == 0);
            rs = ($urandom_range(0, 199) == 0);
            fg = $urandom_range(0, 7);
            drive(v, s, d, us, ud, wr, ld, op, fl, rs, fg);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
